// File: rtl/line_backing_memory.sv
// line_backing_memory: fixed-latency line-granular memory responder for the cache request interface
module line_backing_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 1024,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    mem_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int DW = BLOCK_SIZE*8;
  localparam int CW = $clog2(DELAY+1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] req_idx;
  logic [DW-1:0] req_data;
  logic          req_write;
  logic [DW-1:0] mem [NUM_LINES];
  logic          accept;
  logic          done;
  logic          unused_addr;
  assign unused_addr = ^addr[31:IW];
  assign accept = state == IDLE && is_input_valid && (mem_read || mem_write);
  assign done   = state == WAIT && cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      mem_ready       <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= '0;
      cnt             <= '0;
      read_count      <= '0;
      write_count     <= '0;
    end else begin
      is_output_valid <= 1'b0;
      if (accept) begin
        state     <= WAIT;
        mem_ready <= 1'b0;
        cnt       <= CW'(DELAY-1);
        req_idx   <= addr[IW-1:0];
        req_data  <= din;
        req_write <= mem_write;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (done) begin
        state     <= IDLE;
        mem_ready <= 1'b1;
        if (req_write) begin
          write_count <= write_count + 32'd1;
        end else begin
          dout            <= mem[req_idx];
          is_output_valid <= 1'b1;
          read_count      <= read_count + 32'd1;
        end
      end
    end
  end
  // storage survives reset; a write only commits if reset is low at completion
  always_ff @(posedge clk)
    if (!reset && done && req_write) mem[req_idx] <= req_data;
endmodule
